// File: rtl/ahb_sram_req_if_if.sv
// AHB slave port and SRAM-controller request/response signals for ahb_sram_req_if.
// The slave modport is the bridge's view; master is the bus/controller side.
interface ahb_sram_req_if_if #(
    parameter int unsigned AHB_DWIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 20
);
    // AHB side
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [1:0]            HTRANS;
    logic                  HREADYIN;
    logic [AHB_DWIDTH-1:0] HWDATA;
    logic                  HREADYOUT;
    logic [1:0]            HRESP;
    logic [AHB_DWIDTH-1:0] HRDATA;

    // SRAM controller side
    logic                  ahbsram_req;
    logic                  ahbsram_write;
    logic [2:0]            ahbsram_size;
    logic [ADDR_WIDTH-1:0] ahbsram_addr;
    logic [AHB_DWIDTH-1:0] ahbsram_wdata;
    logic                  sramahb_ack;
    logic [AHB_DWIDTH-1:0] sramahb_rdata;
    logic                  BUSY;

    modport slave (
        input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADYIN, HWDATA,
        input  sramahb_ack, sramahb_rdata, BUSY,
        output HREADYOUT, HRESP, HRDATA,
        output ahbsram_req, ahbsram_write, ahbsram_size, ahbsram_addr, ahbsram_wdata
    );

    modport master (
        output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HREADYIN, HWDATA,
        output sramahb_ack, sramahb_rdata, BUSY,
        input  HREADYOUT, HRESP, HRDATA,
        input  ahbsram_req, ahbsram_write, ahbsram_size, ahbsram_addr, ahbsram_wdata
    );
endinterface

// File: rtl/ahb_sram_req_if.sv
// AHB slave front end that turns each aligned transfer into a single-cycle SRAM
// request, inserts wait states until the controller acks, and flags misaligned accesses.
module ahb_sram_req_if #(
    parameter int unsigned AHB_DWIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 20
) (
    input  logic             HCLK,
    input  logic             HRESET,
    ahb_sram_req_if_if.slave bus
);

    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_ERROR    = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
    localparam logic [2:0] SIZE_HALF     = 3'b001;
    localparam logic [2:0] SIZE_WORD     = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ACK,
        S_RCAP,
        S_FIN,
        S_ERR1,
        S_ERR2
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            size_q, size_d;
    logic                  write_q, write_d;
    logic [AHB_DWIDTH-1:0] rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic [1:0]            resp_q, resp_d;

    logic                  sample_c;
    logic                  active_c;
    logic                  valid_c;
    logic                  misaligned_c;
    logic                  req_c;

    // Address-phase qualification; only IDLE and FIN are ready to accept a new transfer.
    always_comb begin
        sample_c     = (state_q == S_IDLE) || (state_q == S_FIN);
        active_c     = (bus.HTRANS == HTRANS_NONSEQ) || (bus.HTRANS == HTRANS_SEQ);
        valid_c      = sample_c && bus.HSEL && bus.HREADYIN && active_c;
        misaligned_c = (bus.HSIZE > SIZE_WORD)
                    || ((bus.HSIZE == SIZE_HALF) && bus.HADDR[0])
                    || ((bus.HSIZE == SIZE_WORD) && (bus.HADDR[1:0] != 2'b00));
    end

    // Next-state, attribute latch and read-data capture.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        write_d = write_q;
        rdata_d = rdata_q;
        req_c   = 1'b0;

        unique case (state_q)
            S_IDLE, S_FIN: begin
                if (valid_c) begin
                    addr_d  = bus.HADDR;
                    size_d  = bus.HSIZE;
                    write_d = bus.HWRITE;
                    state_d = misaligned_c ? S_ERR1 : S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (!bus.BUSY) begin
                    req_c   = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (bus.sramahb_ack) begin
                    state_d = write_q ? S_FIN : S_RCAP;
                end
            end
            S_RCAP: begin
                rdata_d = bus.sramahb_rdata;
                state_d = S_FIN;
            end
            S_ERR1:  state_d = S_ERR2;
            S_ERR2:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Bus response registers follow the state being entered.
        ready_d = (state_d == S_IDLE) || (state_d == S_FIN) || (state_d == S_ERR2);
        resp_d  = ((state_d == S_ERR1) || (state_d == S_ERR2)) ? RESP_ERROR : RESP_OKAY;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b1;
            resp_q  <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            write_q <= write_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            resp_q  <= resp_d;
        end
    end

    // The request pulse depends on BUSY in the same cycle, so it is driven combinationally.
    assign bus.ahbsram_req   = req_c;
    assign bus.ahbsram_write = write_q;
    assign bus.ahbsram_size  = size_q;
    assign bus.ahbsram_addr  = addr_q;
    assign bus.ahbsram_wdata = bus.HWDATA;
    assign bus.HREADYOUT     = ready_q;
    assign bus.HRESP         = resp_q;
    assign bus.HRDATA        = rdata_q;

endmodule

// File: tb/tb_ahb_sram_req_if.sv
// Self-checking bench for ahb_sram_req_if: directed cases plus randomized transfers
// checked against a transfer-level timing and memory model.
module tb_ahb_sram_req_if;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 20;

    logic HCLK;
    logic HRESET;

    ahb_sram_req_if_if #(.AHB_DWIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    ahb_sram_req_if #(.AHB_DWIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .bus   (bus.slave)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // SRAM controller stand-in: ack one cycle after req, read data the cycle after ack.
    logic          mem_init;
    logic          ack_block;
    logic          ack_inj;
    logic          ack_q   = 1'b0;
    logic [DW-1:0] rdata_q = '0;
    logic [DW-1:0] sram_mem [64];

    always @(posedge HCLK) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) sram_mem[i] <= '0;
        end else if (bus.ahbsram_req && bus.ahbsram_write) begin
            sram_mem[bus.ahbsram_addr[7:2]] <= bus.ahbsram_wdata;
        end
        ack_q <= bus.ahbsram_req && !ack_block;
        if (bus.sramahb_ack) rdata_q <= sram_mem[bus.ahbsram_addr[7:2]];
    end

    assign bus.sramahb_ack   = ack_q | ack_inj;
    assign bus.sramahb_rdata = rdata_q;

    // Reference state
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] ref_mem [64];
    logic [DW-1:0] exp_hrdata;
    logic [AW-1:0] last_addr;
    logic [2:0]    last_size;
    logic          last_write;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_cycle();
        bus.HTRANS = 2'($urandom_range(0, 1));
        bus.HSEL   = 1'($urandom);
        tick();
        #1;
        chk("idle_ready", 64'(bus.HREADYOUT), 64'd1);
        chk("idle_resp", 64'(bus.HRESP), 64'd0);
        chk("idle_req", 64'(bus.ahbsram_req), 64'd0);
        chk("idle_hrdata", 64'(bus.HRDATA), 64'(exp_hrdata));
    endtask

    // Drives one address phase in the current cycle and checks every following cycle
    // up to and including the completing one (FIN, or IDLE after an error).
    task automatic do_xfer(input logic wr, input logic [2:0] sz, input logic [AW-1:0] ad,
                           input logic [DW-1:0] wd, input int busy);
        logic err;
        int   t_req;
        int   t_done;
        err = (sz > 3'd2) || ((sz == 3'd1) && ad[0]) || ((sz == 3'd2) && (ad[1:0] != 2'b00));
        bus.HSEL     = 1'b1;
        bus.HREADYIN = 1'b1;
        bus.HTRANS   = 2'b10;
        bus.HADDR    = ad;
        bus.HSIZE    = sz;
        bus.HWRITE   = wr;
        tick();
        bus.HTRANS = 2'($urandom_range(0, 1));
        bus.HADDR  = AW'($urandom);
        bus.HSIZE  = 3'($urandom);
        bus.HWRITE = 1'($urandom);
        bus.HWDATA = wd;
        last_addr  = ad;
        last_size  = sz;
        last_write = wr;
        if (err) begin
            bus.BUSY = 1'($urandom);
            #1;
            chk("err1_ready", 64'(bus.HREADYOUT), 64'd0);
            chk("err1_resp", 64'(bus.HRESP), 64'd1);
            chk("err1_req", 64'(bus.ahbsram_req), 64'd0);
            chk("err_addr", 64'(bus.ahbsram_addr), 64'(ad));
            tick();
            #1;
            chk("err2_ready", 64'(bus.HREADYOUT), 64'd1);
            chk("err2_resp", 64'(bus.HRESP), 64'd1);
            chk("err2_req", 64'(bus.ahbsram_req), 64'd0);
            tick();
            #1;
            chk("err_end_ready", 64'(bus.HREADYOUT), 64'd1);
            chk("err_end_resp", 64'(bus.HRESP), 64'd0);
            chk("err_end_req", 64'(bus.ahbsram_req), 64'd0);
            chk("err_hrdata", 64'(bus.HRDATA), 64'(exp_hrdata));
            bus.BUSY = 1'b0;
        end else begin
            t_req  = 1 + busy;
            t_done = t_req + (wr ? 2 : 3);
            for (int c = 1; c <= t_done; c++) begin
                bus.BUSY = (c <= busy);
                #1;
                chk("xfer_req", 64'(bus.ahbsram_req), 64'(c == t_req));
                chk("xfer_ready", 64'(bus.HREADYOUT), 64'(c == t_done));
                chk("xfer_resp", 64'(bus.HRESP), 64'd0);
                if (c == t_req) begin
                    chk("req_addr", 64'(bus.ahbsram_addr), 64'(ad));
                    chk("req_size", 64'(bus.ahbsram_size), 64'(sz));
                    chk("req_write", 64'(bus.ahbsram_write), 64'(wr));
                    chk("req_wdata", 64'(bus.ahbsram_wdata), 64'(wd));
                end
                if (c == t_done) begin
                    if (!wr) exp_hrdata = ref_mem[ad[7:2]];
                    chk(wr ? "wr_hrdata_hold" : "rd_hrdata", 64'(bus.HRDATA), 64'(exp_hrdata));
                end
                if (c < t_done) tick();
            end
            if (wr) ref_mem[ad[7:2]] = wd;
            bus.BUSY = 1'b0;
        end
    endtask

    initial begin
        logic          r_wr;
        logic [2:0]    r_sz;
        logic [AW-1:0] r_ad;
        logic [DW-1:0] r_wd;
        int            r_busy;

        for (int i = 0; i < 64; i++) ref_mem[i] = '0;
        exp_hrdata   = '0;
        last_addr    = '0;
        last_size    = '0;
        last_write   = 1'b0;
        mem_init     = 1'b1;
        ack_block    = 1'b0;
        ack_inj      = 1'b0;
        HRESET       = 1'b1;
        bus.HSEL     = 1'b0;
        bus.HADDR    = '0;
        bus.HWRITE   = 1'b0;
        bus.HSIZE    = 3'd0;
        bus.HTRANS   = 2'b00;
        bus.HREADYIN = 1'b1;
        bus.HWDATA   = '0;
        bus.BUSY     = 1'b0;

        // Reset values
        repeat (3) tick();
        #1;
        chk("rst_ready", 64'(bus.HREADYOUT), 64'd1);
        chk("rst_resp", 64'(bus.HRESP), 64'd0);
        chk("rst_req", 64'(bus.ahbsram_req), 64'd0);
        chk("rst_hrdata", 64'(bus.HRDATA), 64'd0);
        chk("rst_addr", 64'(bus.ahbsram_addr), 64'd0);
        chk("rst_size", 64'(bus.ahbsram_size), 64'd0);
        chk("rst_write", 64'(bus.ahbsram_write), 64'd0);
        HRESET   = 1'b0;
        mem_init = 1'b0;
        idle_cycle();

        // Word write then word read at 0x00010, no BUSY
        do_xfer(1'b1, 3'b010, 20'h00010, 32'hDEADBEEF, 0);
        idle_cycle();
        do_xfer(1'b0, 3'b010, 20'h00010, 32'h0, 0);
        idle_cycle();

        // Read with BUSY held for 3 cycles
        do_xfer(1'b0, 3'b010, 20'h00010, 32'h0, 3);
        idle_cycle();

        // Unaligned halfword write is errored, no request
        do_xfer(1'b1, 3'b001, 20'h00003, 32'h12345678, 0);

        // Back-to-back byte write then read of 0x00001, second phase in FIN
        do_xfer(1'b1, 3'b000, 20'h00001, 32'h0000_00C3, 0);
        do_xfer(1'b0, 3'b000, 20'h00001, 32'h0, 0);
        idle_cycle();

        // HTRANS BUSY, HSEL low and HREADYIN low are zero-wait OKAY with no request
        bus.HSEL = 1'b1; bus.HTRANS = 2'b01; bus.HADDR = 20'h00055; bus.HSIZE = 3'd2;
        tick();
        #1;
        chk("htrans_busy_ready", 64'(bus.HREADYOUT), 64'd1);
        chk("htrans_busy_req", 64'(bus.ahbsram_req), 64'd0);
        chk("htrans_busy_addr", 64'(bus.ahbsram_addr), 64'(last_addr));
        bus.HSEL = 1'b0; bus.HTRANS = 2'b10;
        tick();
        #1;
        chk("hsel0_ready", 64'(bus.HREADYOUT), 64'd1);
        chk("hsel0_resp", 64'(bus.HRESP), 64'd0);
        chk("hsel0_req", 64'(bus.ahbsram_req), 64'd0);
        chk("hsel0_size", 64'(bus.ahbsram_size), 64'(last_size));
        bus.HSEL = 1'b1; bus.HREADYIN = 1'b0;
        tick();
        #1;
        chk("hrdyin0_req", 64'(bus.ahbsram_req), 64'd0);
        chk("hrdyin0_write", 64'(bus.ahbsram_write), 64'(last_write));
        bus.HREADYIN = 1'b1;
        idle_cycle();

        // A stray ack outside ACK is ignored
        do_xfer(1'b1, 3'b010, 20'h00000, 32'hA5A55A5A, 0);
        idle_cycle();
        ack_inj = 1'b1;
        tick();
        ack_inj = 1'b0;
        #1;
        chk("stray_ack_ready", 64'(bus.HREADYOUT), 64'd1);
        chk("stray_ack_req", 64'(bus.ahbsram_req), 64'd0);
        tick();
        #1;
        chk("stray_ack_ready2", 64'(bus.HREADYOUT), 64'd1);
        chk("stray_ack_hrdata", 64'(bus.HRDATA), 64'(exp_hrdata));

        // Reset while waiting in ACK, ack arrives after reset
        ack_block  = 1'b1;
        bus.HSEL   = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 20'h00000;
        bus.HSIZE  = 3'd2; bus.HWRITE = 1'b0;
        tick();
        bus.HTRANS = 2'b00;
        #1;
        chk("rstack_req", 64'(bus.ahbsram_req), 64'd1);
        tick();
        #1;
        chk("rstack_wait_ready", 64'(bus.HREADYOUT), 64'd0);
        HRESET = 1'b1;
        tick();
        HRESET  = 1'b0;
        ack_inj = 1'b1;
        #1;
        chk("rstack_ready", 64'(bus.HREADYOUT), 64'd1);
        chk("rstack_resp", 64'(bus.HRESP), 64'd0);
        chk("rstack_hrdata", 64'(bus.HRDATA), 64'd0);
        tick();
        ack_inj   = 1'b0;
        ack_block = 1'b0;
        #1;
        chk("rstack_late_ready", 64'(bus.HREADYOUT), 64'd1);
        chk("rstack_late_req", 64'(bus.ahbsram_req), 64'd0);
        chk("rstack_late_addr", 64'(bus.ahbsram_addr), 64'd0);
        tick();
        #1;
        chk("rstack_no_fin_hrdata", 64'(bus.HRDATA), 64'd0);
        chk("rstack_no_fin_ready", 64'(bus.HREADYOUT), 64'd1);
        exp_hrdata = '0;
        last_addr  = '0;
        last_size  = '0;
        last_write = 1'b0;

        // Randomized transfers, mixing back-to-back and gapped phases
        for (int i = 0; i < 60; i++) begin
            r_sz = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            r_ad = AW'($urandom_range(0, 255)) | AW'($urandom_range(0, 4095) << 8);
            if ($urandom_range(0, 3) != 0) begin
                if (r_sz == 3'd1) r_ad[0] = 1'b0;
                else if (r_sz == 3'd2) r_ad[1:0] = 2'b00;
            end
            r_wr   = 1'($urandom);
            r_wd   = DW'($urandom);
            r_busy = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) idle_cycle();
            do_xfer(r_wr, r_sz, r_ad, r_wd, r_busy);
        end
        idle_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ahb_sram_req_if.md
AHB_SRAM_REQ_IF -- requirements
Module: ahb_sram_req_if

Interface
REQ-001 Parameter AHB_DWIDTH, default 32, data width of the AHB and SRAM-request data buses.
REQ-002 Parameter ADDR_WIDTH, default 20, width of HADDR and ahbsram_addr.
REQ-003 HCLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 HRESET  input  1  reset, synchronous and active-high.
REQ-005 HSEL  input  1  slave select.
REQ-006 HADDR  input  ADDR_WIDTH  AHB address-phase address.
REQ-007 HWRITE  input  1  1 = write, 0 = read.
REQ-008 HSIZE  input  3  transfer size: 000 byte, 001 halfword, 010 word.
REQ-009 HTRANS  input  2  transfer type; bit 1 set = NONSEQ or SEQ.
REQ-010 HREADYIN  input  1  bus-level ready; previous transfer is complete.
REQ-011 HWDATA  input  AHB_DWIDTH  write data, valid in the data phase.
REQ-012 HREADYOUT  output  1  slave ready; 0 inserts wait states.
REQ-013 HRESP  output  2  00 OKAY, 01 ERROR.
REQ-014 HRDATA  output  AHB_DWIDTH  registered read data.
REQ-015 ahbsram_req  output  1  single-cycle request pulse to the SRAM controller.
REQ-016 ahbsram_write, ahbsram_size[2:0], ahbsram_addr[ADDR_WIDTH-1:0]  output  latched attributes of the current transfer.
REQ-017 ahbsram_wdata  output  AHB_DWIDTH  equal to HWDATA.
REQ-018 sramahb_ack  input  1  completion strobe from the controller; it arrives one cycle after ahbsram_req.
REQ-019 sramahb_rdata  input  AHB_DWIDTH  read data, valid in the cycle after sramahb_ack.
REQ-020 BUSY  input  1  SRAM busy; blocks request issue.

Function
REQ-021 Valid address phase: HSEL & HREADYIN & HTRANS[1], sampled only in states IDLE and FIN.
REQ-022 On a valid phase, latch HADDR, HSIZE and HWRITE into the ahbsram_* attribute registers; these registers hold their value until the next valid phase.
REQ-023 A valid phase with HSIZE > 010, halfword with HADDR[0] = 1, or word with HADDR[1:0] != 00 shall go to ERR1; all other valid phases go to REQ.
REQ-024 States: IDLE, REQ, ACK, RCAP, FIN, ERR1, ERR2; encoding is free.
REQ-025 IDLE and FIN: HREADYOUT = 1, HRESP = 00; no valid phase -> IDLE.
REQ-026 REQ: HREADYOUT = 0. If BUSY = 0, pulse ahbsram_req = 1 for exactly this cycle and go to ACK; if BUSY = 1, remain in REQ with ahbsram_req = 0.
REQ-027 ACK: HREADYOUT = 0, ahbsram_req = 0. On sramahb_ack, a write goes to FIN and a read goes to RCAP; otherwise remain in ACK.
REQ-028 RCAP: HREADYOUT = 0; HRDATA <= sramahb_rdata; go to FIN.
REQ-029 ERR1: HREADYOUT = 0, HRESP = 01, go to ERR2. ERR2: HREADYOUT = 1, HRESP = 01, go to IDLE; no SRAM request is issued for an errored transfer.
REQ-030 Latency with BUSY = 0, address phase in cycle A:
  - write: ahbsram_req in A+1, HREADYOUT = 1 in A+3 (2 wait states).
  - read: ahbsram_req in A+1, HRDATA valid with HREADYOUT = 1 in A+4 (3 wait states).
REQ-031 A valid phase accepted in FIN shall enter REQ the next cycle (back-to-back transfers); the new attributes replace the old ones only at that edge.
REQ-032 sramahb_ack in any state other than ACK shall be ignored.
REQ-033 HTRANS IDLE/BUSY, or HSEL = 0, shall complete with zero wait states and an OKAY response, with no request issued.
REQ-034 HRDATA shall change only in RCAP and in reset.
REQ-035 ahbsram_req shall never be high in two consecutive cycles.

Reset
REQ-036 While HRESET = 1 at a rising edge:
  - state <= IDLE;
  - HRDATA, ahbsram_addr, ahbsram_size and ahbsram_write <= 0;
  - HREADYOUT = 1, HRESP = 00, ahbsram_req = 0 thereafter.
REQ-037 A reset asserted in REQ, ACK or RCAP shall abandon the transfer; a late sramahb_ack after reset shall be ignored.

Verification
REQ-038 Word write: HADDR 0x00010, HWDATA 0xDEADBEEF, ack one cycle after req -> req pulse in A+1 with addr 0x00010, size 010, write = 1; HREADYOUT = 1 in A+3.
REQ-039 Word read at 0x00010, controller returns 0xDEADBEEF the cycle after ack -> HRDATA = 0xDEADBEEF with HREADYOUT = 1 in A+4; HRESP = 00.
REQ-040 BUSY held high for 3 cycles after a read address phase -> no req while BUSY = 1; a single req in the first cycle BUSY = 0; HREADYOUT stays 0 until FIN.
REQ-041 Unaligned halfword write to HADDR 0x00003 -> HRESP = 01 for 2 cycles, HREADYOUT 0 then 1; ahbsram_req never asserted.
REQ-042 Back-to-back byte write to 0x00001 then read of 0x00001, with the second address phase in FIN:
  - the second req fires the cycle after FIN;
  - sizes 000/000 and write flags 1/0 are presented in order.
REQ-043 HRESET asserted in ACK with ack arriving after reset -> IDLE, HREADYOUT = 1, no FIN, HRDATA = 0.
